// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux block: FSM state encoding and the
// select/index width helper.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_e;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Round-robin channel pointer with a per-channel dwell counter; flags the
// cycle in which the pointer has just wrapped from N-1 back to 0.
module scan_counter
  import scan_mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int DWELL = 4,
  parameter int SW    = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [SW-1:0] cur_o,
  output logic          wrap_o
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [SW-1:0] cur_q, cur_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          wrapped_q, wrapped_d;

  always_comb begin
    cur_d     = cur_q;
    dwell_d   = dwell_q;
    wrapped_d = wrapped_q;
    if (clr_i) begin
      cur_d     = '0;
      dwell_d   = '0;
      wrapped_d = 1'b0;
    end else if (adv_i) begin
      wrapped_d = 1'b0;
      if (dwell_q == DW'(DWELL - 1)) begin
        dwell_d = '0;
        // Explicit wrap so non-power-of-two N never walks past N-1.
        if (cur_q == SW'(N - 1)) begin
          cur_d     = '0;
          wrapped_d = 1'b1;
        end else begin
          cur_d = cur_q + SW'(1);
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q     <= '0;
      dwell_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      dwell_q   <= dwell_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign cur_o  = cur_q;
  assign wrap_o = wrapped_q;

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel, W-bit multiplexer with manual select and automatic
// round-robin scan; ch always names the channel presented on dout.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  parameter int SW    = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  ch,
  output logic           valid,
  output logic           wrap
);

  state_e        state_q, state_d;
  logic [SW-1:0] cur;
  logic          cnt_wrap;
  logic [SW-1:0] idx;
  logic          in_range;
  logic [W-1:0]  pick;

  logic [W-1:0]  dout_q, dout_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;

  always_comb begin
    state_d = IDLE;
    if (en) state_d = mode ? SCAN : MAN;
  end

  // Counters run only while the next state is SCAN, so any entry starts at 0.
  scan_counter #(
    .N    (N),
    .DWELL(DWELL),
    .SW   (SW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_d != SCAN),
    .adv_i (state_d == SCAN),
    .cur_o (cur),
    .wrap_o(cnt_wrap)
  );

  always_comb begin
    idx      = (state_d == SCAN) ? cur : sel;
    in_range = 32'(idx) < N;
    pick     = in_range ? din[idx*W +: W] : '0;
  end

  always_comb begin
    dout_d  = dout_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    case (state_d)
      MAN: begin
        dout_d  = pick;
        ch_d    = sel;
        valid_d = in_range;
      end
      SCAN: begin
        dout_d  = pick;
        ch_d    = cur;
        valid_d = 1'b1;
        wrap_d  = (state_q == SCAN) && cnt_wrap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dout  = dout_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: an N=8/W=1/DWELL=4 instance and an
// N=5/W=4/DWELL=1 instance sharing clock and reset.
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: N=8, W=1, DWELL=4
  logic       en_a, mode_a;
  logic [2:0] sel_a;
  logic [7:0] din_a;
  logic       dout_a;
  logic [2:0] ch_a;
  logic       valid_a, wrap_a;

  // Instance B: N=5, W=4, DWELL=1
  logic        en_b, mode_b;
  logic [2:0]  sel_b;
  logic [19:0] din_b;
  logic [3:0]  dout_b;
  logic [2:0]  ch_b;
  logic        valid_b, wrap_b;

  scan_mux #(.N(8), .W(1), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a),
    .din(din_a), .dout(dout_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a)
  );

  scan_mux #(.N(5), .W(4), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b),
    .din(din_b), .dout(dout_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  pat;
  logic [3:0]  exp_b [0:5];

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; mode_a = 1'b0; sel_a = '0; din_a = '0;
    en_b = 1'b0; mode_b = 1'b0; sel_b = '0; din_b = '0;
    exp_b[0] = 4'hA; exp_b[1] = 4'h3; exp_b[2] = 4'hF;
    exp_b[3] = 4'h0; exp_b[4] = 4'h7; exp_b[5] = 4'hA;

    // Reset values
    step(); step();
    chk("rst_dout", 32'(dout_a), 32'd0);
    chk("rst_ch", 32'(ch_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_wrap", 32'(wrap_a), 32'd0);

    // Release; en=0 keeps everything at reset values
    rst_n = 1'b1;
    din_a = 8'hFF;
    step();
    chk("idle_valid", 32'(valid_a), 32'd0);
    chk("idle_dout", 32'(dout_a), 32'd0);
    chk("idle_ch", 32'(ch_a), 32'd0);

    // Manual one-hot sweep
    en_a = 1'b1; mode_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pat = 8'd1 << k;
      din_a = pat;
      sel_a = 3'(k);
      step();
      chk("man_dout", 32'(dout_a), 32'd1);
      chk("man_ch", 32'(ch_a), 32'(k));
      chk("man_valid", 32'(valid_a), 32'd1);
      chk("man_wrap", 32'(wrap_a), 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      pat = 8'd1 << ((k + 3) % 8);
      din_a = pat;
      sel_a = 3'(k);
      step();
      chk("man_other_dout", 32'(dout_a), 32'd0);
      chk("man_other_valid", 32'(valid_a), 32'd1);
    end

    // Auto scan, DWELL=4, din=1010_0101
    din_a = 8'hA5;
    pat = 8'hA5;
    mode_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("scan_ch", 32'(ch_a), 32'((i / 4) % 8));
      chk("scan_dout", 32'(dout_a), 32'(pat[(i / 4) % 8]));
      chk("scan_valid", 32'(valid_a), 32'd1);
      chk("scan_wrap", 32'(wrap_a), (i == 32) ? 32'd1 : 32'd0);
    end

    // Leave scan, re-enter, abandon mid-dwell at ch=3 dwell=2
    en_a = 1'b0;
    step();
    chk("scan_off_valid", 32'(valid_a), 32'd0);
    en_a = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("pre_switch_ch", 32'(ch_a), 32'd3);
    mode_a = 1'b0; sel_a = 3'd6;
    step();
    chk("switch_ch", 32'(ch_a), 32'd6);
    chk("switch_dout", 32'(dout_a), 32'd0);
    chk("switch_valid", 32'(valid_a), 32'd1);
    mode_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("restart_ch", 32'(ch_a), 32'd0);
      chk("restart_dout", 32'(dout_a), 32'd1);
      chk("restart_wrap", 32'(wrap_a), 32'd0);
    end
    step();
    chk("restart_next_ch", 32'(ch_a), 32'd1);

    // en=0 holds dout/ch, drops valid
    mode_a = 1'b0; sel_a = 3'd5;
    step();
    chk("hold_pre_ch", 32'(ch_a), 32'd5);
    chk("hold_pre_dout", 32'(dout_a), 32'd1);
    en_a = 1'b0;
    din_a = 8'h00;
    step();
    chk("hold_valid", 32'(valid_a), 32'd0);
    chk("hold_dout", 32'(dout_a), 32'd1);
    chk("hold_ch", 32'(ch_a), 32'd5);
    chk("hold_wrap", 32'(wrap_a), 32'd0);
    step();
    chk("hold2_dout", 32'(dout_a), 32'd1);
    chk("hold2_ch", 32'(ch_a), 32'd5);

    // Asynchronous reset mid-scan
    din_a = 8'hA5;
    en_a = 1'b1; mode_a = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("prerst_ch", 32'(ch_a), 32'd1);
    chk("prerst_valid", 32'(valid_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dout", 32'(dout_a), 32'd0);
    chk("async_ch", 32'(ch_a), 32'd0);
    chk("async_valid", 32'(valid_a), 32'd0);
    chk("async_wrap", 32'(wrap_a), 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_ch", 32'(ch_a), 32'd0);
    chk("post_rst_valid", 32'(valid_a), 32'd1);
    step(); step(); step(); step();
    chk("post_rst_ch1", 32'(ch_a), 32'd1);
    en_a = 1'b0;

    // Instance B: N=5, W=4, DWELL=1
    din_b = 20'h70F3A;
    en_b = 1'b1; mode_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("b_scan_ch", 32'(ch_b), 32'(i % 5));
      chk("b_scan_dout", 32'(dout_b), 32'(exp_b[i]));
      chk("b_scan_valid", 32'(valid_b), 32'd1);
      chk("b_scan_wrap", 32'(wrap_b), (i == 5) ? 32'd1 : 32'd0);
    end
    mode_b = 1'b0; sel_b = 3'd6;
    step();
    chk("b_oor_valid", 32'(valid_b), 32'd0);
    chk("b_oor_dout", 32'(dout_b), 32'd0);
    chk("b_oor_ch", 32'(ch_b), 32'd6);
    sel_b = 3'd2;
    step();
    chk("b_man_dout", 32'(dout_b), 32'hF);
    chk("b_man_valid", 32'(valid_b), 32'd1);
    sel_b = 3'd5;
    step();
    chk("b_sel5_valid", 32'(valid_b), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
